// File: rtl/encap_run_sequencer_pkg.sv
// Shared types and constants for the encapsulation run sequencer.
// State encoding, width helpers and status LED bit map.
package encap_run_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_LOAD,
    S_WAIT,
    S_DONE,
    S_TIMEOUT
  } state_t;

  function automatic int addr_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  function automatic int sel_width(input int n_ev);
    return (n_ev > 0) ? $clog2(n_ev + 1) : 1;
  endfunction

  localparam int LED_LOAD    = 0;
  localparam int LED_DONE    = 1;
  localparam int LED_EV0     = 2;
  localparam int LED_EV_MAX  = 5;
  localparam int LED_TIMEOUT = 7;

endpackage

// File: rtl/encap_run_sequencer_stamp.sv
// Multi-lane rising-edge detector with first-edge timestamp capture.
// The top lane can be forced to all-ones to mark an aborted run.
module event_stamp_unit #(
  parameter int LANES = 3,
  parameter int CW    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      enable,
  input  logic                      saturate_last,
  input  logic [LANES-1:0]          levels,
  input  logic [CW-1:0]             counter,
  output logic                      last_rise,
  output logic [LANES-1:0][CW-1:0]  stamps,
  output logic [LANES-1:0]          seen
);

  logic [LANES-1:0] prev;
  logic [LANES-1:0] rise;

  assign rise      = levels & ~prev;
  assign last_rise = rise[LANES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      prev   <= '0;
      stamps <= '0;
      seen   <= '0;
    end else begin
      prev <= levels;
      if (clear) begin
        stamps <= '0;
        seen   <= '0;
      end else begin
        for (int i = 0; i < LANES; i++) begin
          if (enable && rise[i] && !seen[i]) begin
            stamps[i] <= counter;
            seen[i]   <= 1'b1;
          end
        end
        if (saturate_last)
          stamps[LANES-1] <= '1;
      end
    end
  end

endmodule

// File: rtl/encap_run_sequencer.sv
// Seed loader and cycle profiler in front of the encapsulation core.
// Streams a seed from a registered RAM, then timestamps core events.
module encap_run_sequencer
  import encap_run_sequencer_pkg::*;
#(
  parameter int SEED_WORDS     = 16,
  parameter int SEED_WIDTH     = 32,
  parameter int N_EV           = 2,
  parameter int CTR_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic [addr_width(SEED_WORDS)-1:0] seed_addr,
  input  logic [SEED_WIDTH-1:0]             seed_rdata,
  output logic                              seed_valid,
  output logic [SEED_WIDTH-1:0]             seed,
  input  logic [N_EV-1:0]                   ev,
  input  logic                              done,
  output logic                              busy,
  output logic                              run_done,
  output logic                              timeout_err,
  output logic [N_EV-1:0]                   ev_seen,
  input  logic [sel_width(N_EV)-1:0]        stamp_sel,
  output logic [CTR_WIDTH-1:0]              stamp_data,
  output logic [15:0]                       run_count,
  output logic [7:0]                        led
);

  localparam int AW   = addr_width(SEED_WORDS);
  localparam int SW   = sel_width(N_EV);
  localparam int NLED = (N_EV < LED_EV_MAX) ? N_EV : LED_EV_MAX;
  localparam logic [AW-1:0] LAST = AW'(SEED_WORDS - 1);
  localparam logic [CTR_WIDTH-1:0] TMO_LAST =
    CTR_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam bit TMO_ON = (TIMEOUT_CYCLES != 0);

  state_t state, state_nx;

  logic [AW-1:0]                  word_idx;
  logic [CTR_WIDTH-1:0]           cnt;
  logic [7:0]                     led_q;
  logic [N_EV:0][CTR_WIDTH-1:0]   stamps;
  logic [N_EV:0]                  seen;
  logic                           last_rise;
  logic                           capture;
  logic                           done_rise;
  logic                           accept;
  logic                           tmo_hit;
  logic                           cnt_inc;

  assign capture   = (state == S_LOAD) || (state == S_WAIT);
  assign done_rise = capture & last_rise;
  assign busy      = (state == S_PREFETCH) || capture;
  assign ev_seen   = seen[N_EV-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    tmo_hit  = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = S_PREFETCH;
        end
      end
      S_PREFETCH: state_nx = S_LOAD;
      S_LOAD: begin
        // counter reads 0 while the first word is on the bus
        cnt_inc = (word_idx != '0);
        if (done_rise)             state_nx = S_DONE;
        else if (word_idx == LAST) state_nx = S_WAIT;
      end
      S_WAIT: begin
        cnt_inc = 1'b1;
        if (done_rise) begin
          state_nx = S_DONE;
        end else if (TMO_ON && cnt == TMO_LAST) begin
          tmo_hit  = 1'b1;
          state_nx = S_TIMEOUT;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_addr   <= '0;
      word_idx    <= '0;
      cnt         <= '0;
      seed_valid  <= 1'b0;
      seed        <= '0;
      run_done    <= 1'b0;
      timeout_err <= 1'b0;
      run_count   <= '0;
      led_q       <= '0;
    end else begin
      run_done   <= done_rise | tmo_hit;
      seed_valid <= (state == S_LOAD);
      led_q      <= led;
      if (state == S_LOAD) begin
        seed     <= seed_rdata;
        word_idx <= word_idx + 1'b1;
      end
      if (busy && state != S_WAIT && seed_addr != LAST)
        seed_addr <= seed_addr + 1'b1;
      if (cnt_inc && cnt != '1)
        cnt <= cnt + 1'b1;
      if ((done_rise | tmo_hit) && run_count != 16'hFFFF)
        run_count <= run_count + 16'd1;
      if (tmo_hit)
        timeout_err <= 1'b1;
      if (accept) begin
        seed_addr       <= '0;
        word_idx        <= '0;
        cnt             <= '0;
        timeout_err     <= 1'b0;
        led_q[LED_LOAD] <= 1'b1;
      end
    end
  end

  // status is history OR the live flags, so a capture shows at once
  always_comb begin
    led = led_q;
    led[LED_DONE]    = led_q[LED_DONE] | seen[N_EV];
    led[LED_TIMEOUT] = led_q[LED_TIMEOUT] | timeout_err;
    for (int i = 0; i < NLED; i++)
      led[LED_EV0+i] = led_q[LED_EV0+i] | seen[i];
  end

  always_comb begin
    stamp_data = '0;
    for (int i = 0; i <= N_EV; i++)
      if (stamp_sel == SW'(i))
        stamp_data = stamps[i];
  end

  event_stamp_unit #(
    .LANES (N_EV + 1),
    .CW    (CTR_WIDTH)
  ) u_stamp (
    .clk           (clk),
    .rst           (rst),
    .clear         (accept),
    .enable        (capture),
    .saturate_last (tmo_hit),
    .levels        ({done, ev}),
    .counter       (cnt),
    .last_rise     (last_rise),
    .stamps        (stamps),
    .seen          (seen)
  );

endmodule

// File: doc/encap_run_sequencer.md
Name: encap_run_sequencer

Overview:
- Synthesizable successor to the bench-side seed loader and cycle profiler around encap_seq_gen.
- Reads a SEED_WORDS-deep seed from a registered-output single-port RAM and streams it to the encapsulation core with a valid strobe.
- Timestamps N_EV internal completion events and the final done; supports a timeout and repeated runs without reset.
- Sits between the seed RAM and encap_seq_gen on FPGA builds. Results are read out over a small select/data port and sticky status LEDs.

Parameters:
- SEED_WORDS, 16: seed words per run; must be ≥1.
- SEED_WIDTH, 32: width of a seed word.
- N_EV, 2: number of monitored event inputs, for example done_error and done_encrypt.
- CTR_WIDTH, 32: width of the cycle counter and timestamps.
- TIMEOUT_CYCLES, 0: abort threshold in cycles; 0 disables the timeout.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, synchronous, active-high.
- start, in, 1: run request pulse; sampled only in IDLE, DONE or TIMEOUT.
- seed_addr, out, clog2(SEED_WORDS) (min 1): seed RAM address; RAM data returns one cycle later.
- seed_rdata, in, SEED_WIDTH: seed RAM read data.
- seed_valid, out, 1: seed word strobe to the core.
- seed, out, SEED_WIDTH: seed word to the core.
- ev, in, N_EV: event levels from the core.
- done, in, 1: core done level.
- busy, out, 1: high in PREFETCH, LOAD and WAIT.
- run_done, out, 1: one-cycle pulse on done capture or timeout.
- timeout_err, out, 1: sticky; set when a run times out.
- ev_seen, out, N_EV: sticky per event, set on first capture in the current run.
- stamp_sel, in, clog2(N_EV+1): selects 0..N_EV-1 for event stamps, N_EV for the total.
- stamp_data, out, CTR_WIDTH: combinational mux of the selected stamp.
- run_count, out, 16: completed runs (done or timeout); saturates at 0xFFFF.
- led, out, 8: sticky status. Bit 0 = seed load started, 1 = done seen, 2..(1+min(N_EV,5)) = ev_seen, 7 = timeout_err.

Behaviour:
- Reset: all registers are 0 and state is IDLE. This applies whenever rst is high, including mid-run; the run is abandoned and any in-flight RAM data is discarded.
- FSM states: IDLE, PREFETCH, LOAD, WAIT, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT + start → PREFETCH:
  - seed_addr←0.
  - stamps, ev_seen, timeout_err and the cycle counter cleared.
  - ev/done edge history reloaded from the current input levels, so a level already high is not an edge.
- PREFETCH → LOAD after one cycle; seed_addr advances to 1.
- LOAD, cycle j (j = 0..SEED_WORDS-1):
  - registered seed_valid=1 and seed=seed_rdata, so word j appears on the core interface exactly 3 cycles after start is sampled, contiguous, no gaps.
  - seed_addr increments each cycle, holds at SEED_WORDS-1 and does not wrap.
  - After the last word: LOAD → WAIT, and seed_valid=0 on the next cycle.
- Cycle counter:
  - Zero on the cycle the first seed word is valid; then increments by 1 per cycle in LOAD and WAIT.
  - Saturates at all-ones and never wraps.
- Event capture:
  - Rising edge = input high now and low in the previous sample.
  - Captured only in LOAD and WAIT; edges in other states are ignored. The first edge on ev[i] stores counter→stamp[i] and sets ev_seen[i]; later edges are ignored.
- Done:
  - A rising edge in LOAD or WAIT stores counter→stamp[N_EV] and moves to DONE with a run_done pulse and run_count+1.
  - If done and ev[i] edges occur in the same cycle, both capture the same value.
- Timeout: when TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1 in WAIT with no done edge, go to TIMEOUT.
  - timeout_err=1, run_done pulse, run_count+1.
  - stamp[N_EV] = all-ones.
  - A done edge in the same cycle wins, giving DONE rather than TIMEOUT.
- start while busy is ignored, with no effect on the current run.
- The led bits are cleared only by rst and are not cleared by a new start.
- stamp_sel > N_EV reads 0.

Decomposition:
- A shared package holds the FSM state encoding, the localparams for address width (clog2 of SEED_WORDS, min 1) and select width, and the LED bit indices.
- One sub-module, event_stamp_unit: an N_EV+1 lane edge detector with first-edge capture and sticky seen flags, with clear, enable and counter inputs.

Test Plan:
1. Defaults; RAM word i = 0xA5000000+i; start pulse → seed_valid high for exactly 16 cycles beginning 3 cycles after start; seed sequence 0xA5000000..0xA500000F in order.
2. ev[0] rises 100 cycles after the first seed word, ev[1] at 250, done at 400 → stamps 100, 250, 400; ev_seen=2'b11; one run_done pulse; run_count=1; led=8'b0000_1111.
3. done and ev[1] rise in the same cycle at count 57; ev[0] never rises → stamp[1]=57, stamp[2]=57, ev_seen=2'b10.
4. TIMEOUT_CYCLES=64, done never rises → TIMEOUT 64 cycles after the first seed word (counter 63); timeout_err=1; stamp[N_EV]=0xFFFFFFFF; led[7]=1. A subsequent start clears timeout_err and the run completes normally.
5. start pulsed during LOAD and again during WAIT → no restart, seed stream unbroken; done then gives run_count=1. A second start after DONE gives run_count=2 with fresh stamps.
6. rst asserted during LOAD word 7 → the next cycle shows seed_valid=0, busy=0, run_count=0, led=0. A new start gives a full 16-word stream from word 0.
